bus_arbiter: RTL

//   Sequences the shared system bus (BUS_A/BUS_D/BUS_R/BUS_W) among three requesters:

---
 rtl/bus_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Shared system bus sequencer for the memory (M), fetch (F) and external (X) requesters.
// Fixed M > F > X priority, with an anti-starvation override for X and programmable wait states.
module bus_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        _CLK,
  input  logic        RST,
  input  logic        M_REQ,
  input  logic        M_WE,
  input  logic [22:0] M_A,
  input  logic [15:0] M_WD,
  output logic        M_ACK,
  input  logic        F_REQ,
  input  logic        F_WE,
  input  logic [22:0] F_A,
  input  logic [15:0] F_WD,
  output logic        F_ACK,
  input  logic        X_REQ,
  input  logic        X_WE,
  input  logic [22:0] X_A,
  input  logic [15:0] X_WD,
  output logic        X_ACK,
  output logic [15:0] RD,
  output logic        M_WAIT,
  output logic        F_WAIT,
  output logic [22:0] BUS_A,
  inout  wire  [15:0] BUS_D,
  output logic        BUS_R,
  output logic        BUS_W
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;
  typedef enum logic [1:0] {G_M, G_F, G_X} gnt_e;

  state_e      state_q;
  gnt_e        gnt_q;
  gnt_e        sel;
  logic        we_q;
  logic [15:0] wd_q;
  logic [3:0]  wcnt_q;
  logic [3:0]  starve_q;
  logic [2:0]  ack_q;
  logic [15:0] rd_q;
  logic [22:0] bus_a_q;
  logic        bus_r_q;
  logic        bus_w_q;
  logic        drive_q;
  logic        req_any;
  logic        force_x;
  logic        sel_we;
  logic [22:0] sel_a;
  logic [15:0] sel_wd;

  always_comb begin
    req_any = M_REQ | F_REQ | X_REQ;
    force_x = X_REQ && (starve_q == 4'(STARVE_LIMIT));
    sel     = G_X;
    if (force_x)    sel = G_X;
    else if (M_REQ) sel = G_M;
    else if (F_REQ) sel = G_F;
    sel_we = X_WE;
    sel_a  = X_A;
    sel_wd = X_WD;
    case (sel)
      G_M: begin sel_we = M_WE; sel_a = M_A; sel_wd = M_WD; end
      G_F: begin sel_we = F_WE; sel_a = F_A; sel_wd = F_WD; end
      default: ;
    endcase
  end

  always_ff @(posedge _CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      gnt_q    <= G_M;
      we_q     <= 1'b0;
      wd_q     <= '0;
      wcnt_q   <= '0;
      starve_q <= '0;
      ack_q    <= '0;
      rd_q     <= '0;
      bus_a_q  <= '0;
      bus_r_q  <= 1'b0;
      bus_w_q  <= 1'b0;
      drive_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          // Counter only advances on an M/F grant that overtook a waiting X.
          if (!X_REQ || sel == G_X)
            starve_q <= '0;
          else if (starve_q < 4'(STARVE_LIMIT))
            starve_q <= starve_q + 4'd1;
          if (req_any) begin
            gnt_q   <= sel;
            we_q    <= sel_we;
            wd_q    <= sel_wd;
            wcnt_q  <= 4'(WAIT_CYCLES);
            bus_a_q <= sel_a;
            bus_r_q <= ~sel_we;
            bus_w_q <= sel_we;
            drive_q <= sel_we;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (wcnt_q == 4'd0) begin
            if (!we_q) rd_q <= BUS_D;
            bus_a_q <= '0;
            bus_r_q <= 1'b0;
            bus_w_q <= 1'b0;
            drive_q <= 1'b0;
            ack_q   <= 3'b001 << gnt_q;
            state_q <= DONE;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        DONE: begin
          ack_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUS_D  = drive_q ? wd_q : 'z;
  assign BUS_A  = bus_a_q;
  assign BUS_R  = bus_r_q;
  assign BUS_W  = bus_w_q;
  assign RD     = rd_q;
  assign M_ACK  = ack_q[0];
  assign F_ACK  = ack_q[1];
  assign X_ACK  = ack_q[2];
  assign M_WAIT = M_REQ & ~M_ACK;
  assign F_WAIT = F_REQ & ~F_ACK;

endmodule
